// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR fault-injection campaign logic.
// Also carries the bitwise majority function used by voters and benches.
package tmr_pkg;

    typedef enum logic [1:0] {
        ORI = 2'd0,
        MAI = 2'd1,
        MEN = 2'd2,
        ROT = 2'd3
    } target_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_INJECT,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int MAJ_W = 32;

    function automatic logic [MAJ_W-1:0] maj3(
        input logic [MAJ_W-1:0] a,
        input logic [MAJ_W-1:0] b,
        input logic [MAJ_W-1:0] c
    );
        return (a & b) | (b & c) | (a & c);
    endfunction

    // Replica used as the fault-free reference for a given target
    function automatic target_e next_rep(input target_e t);
        case (t)
            ORI:     next_rep = MAI;
            MAI:     next_rep = MEN;
            default: next_rep = ORI;
        endcase
    endfunction

endpackage

// File: rtl/atmr_fault_injector_if.sv
// Campaign control, replica observation and flip-mask bundle
// between a campaign host and the fault injector.
interface atmr_fault_injector_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] n_inject;
    logic [1:0]       target;
    logic             multi_bit;
    logic [WIDTH-1:0] rep_ori;
    logic [WIDTH-1:0] rep_mai;
    logic [WIDTH-1:0] rep_men;
    logic [WIDTH-1:0] voted;
    logic [WIDTH-1:0] inj_ori;
    logic [WIDTH-1:0] inj_mai;
    logic [WIDTH-1:0] inj_men;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] masked_cnt;
    logic [CNT_W-1:0] escaped_cnt;
    logic [WIDTH-1:0] disagree;

    modport master (
        output start, n_inject, target, multi_bit,
        output rep_ori, rep_mai, rep_men, voted,
        input  inj_ori, inj_mai, inj_men,
        input  busy, done, masked_cnt, escaped_cnt, disagree
    );

    modport slave (
        input  start, n_inject, target, multi_bit,
        input  rep_ori, rep_mai, rep_men, voted,
        output inj_ori, inj_mai, inj_men,
        output busy, done, masked_cnt, escaped_cnt, disagree
    );
endinterface

// File: rtl/atmr_lfsr16.sv
// 16-bit Galois LFSR picking flip positions; reseeded only by reset.
module atmr_lfsr16
    import tmr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/atmr_fault_injector.sv
// Drives per-replica flip masks, waits for settling, then scores the
// voted bus against a fault-free replica as masked or escaped.
module atmr_fault_injector
    import tmr_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    atmr_fault_injector_if.slave  bus
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int SW    = $clog2(SETTLE_CYC + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cfg_n, rem;
    target_e          cfg_tgt, ptr, cur_tgt;
    logic             cfg_multi;
    logic [SW-1:0]    settle;
    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic [IDX_W-1:0] raw, idx, idx_nx;
    logic [WIDTH-1:0] mask, golden;
    logic [WIDTH-1:0] inj_ori, inj_mai, inj_men, disagree;
    logic [CNT_W-1:0] masked, escaped;

    atmr_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (state_q == S_INJECT),
        .state   (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:IDX_W];
    assign raw         = lfsr[IDX_W-1:0];
    assign cur_tgt     = (cfg_tgt == ROT) ? ptr : cfg_tgt;

    always_comb begin
        idx = raw;
        if (int'(raw) >= WIDTH) idx = IDX_W'(int'(raw) - WIDTH);
        idx_nx = (int'(idx) == WIDTH - 1) ? '0 : idx + IDX_W'(1);
        mask = WIDTH'(1) << idx;
        if (cfg_multi) mask = mask | (WIDTH'(1) << idx_nx);
    end

    always_comb begin
        golden = bus.rep_ori;
        case (cur_tgt)
            ORI:     golden = bus.rep_mai;
            MAI:     golden = bus.rep_men;
            default: golden = bus.rep_ori;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_ARM;
            S_ARM:    state_d = (cfg_n == '0) ? S_DONE : S_INJECT;
            S_INJECT: state_d = S_SETTLE;
            S_SETTLE: if (settle == '0) state_d = S_CHECK;
            S_CHECK:  state_d = (rem == CNT_W'(1)) ? S_DONE : S_INJECT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_n     <= '0;
            cfg_tgt   <= ORI;
            cfg_multi <= 1'b0;
            rem       <= '0;
            ptr       <= ORI;
            settle    <= '0;
            inj_ori   <= '0;
            inj_mai   <= '0;
            inj_men   <= '0;
            masked    <= '0;
            escaped   <= '0;
            disagree  <= '0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                cfg_n     <= bus.n_inject;
                cfg_tgt   <= target_e'(bus.target);
                cfg_multi <= bus.multi_bit;
            end
            if (state_q == S_ARM) begin
                masked   <= '0;
                escaped  <= '0;
                disagree <= '0;
                rem      <= cfg_n;
                ptr      <= ORI;
            end
            if (state_q == S_INJECT) begin
                inj_ori <= (cur_tgt == ORI) ? mask : '0;
                inj_mai <= (cur_tgt == MAI) ? mask : '0;
                inj_men <= (cur_tgt == MEN) ? mask : '0;
                settle  <= SW'(SETTLE_CYC - 1);
            end
            if (state_q == S_SETTLE && settle != '0) begin
                settle <= settle - SW'(1);
            end
            if (state_q == S_CHECK) begin
                if (bus.voted == golden) begin
                    if (masked != '1) masked <= masked + CNT_W'(1);
                end else begin
                    if (escaped != '1) escaped <= escaped + CNT_W'(1);
                end
                disagree <= (bus.rep_ori ^ bus.rep_mai) |
                            (bus.rep_mai ^ bus.rep_men);
                rem <= rem - CNT_W'(1);
                if (cfg_tgt == ROT) ptr <= next_rep(ptr);
                if (rem == CNT_W'(1)) begin
                    inj_ori <= '0;
                    inj_mai <= '0;
                    inj_men <= '0;
                end
            end
            if (state_q == S_DONE) begin
                inj_ori <= '0;
                inj_mai <= '0;
                inj_men <= '0;
            end
        end
    end

    assign bus.inj_ori     = inj_ori;
    assign bus.inj_mai     = inj_mai;
    assign bus.inj_men     = inj_men;
    assign bus.masked_cnt  = masked;
    assign bus.escaped_cnt = escaped;
    assign bus.disagree    = disagree;
    assign bus.done        = (state_q == S_DONE);
    assign bus.busy        = (state_q == S_ARM) || (state_q == S_INJECT) ||
                             (state_q == S_SETTLE) || (state_q == S_CHECK);

endmodule

// File: tb/tb_atmr_fault_injector.sv
// Campaign-level bench: bench-side replicas and voter, LFSR reference
// and an injection scoreboard checked against the injector outputs.
module tb_atmr_fault_injector;
    import tmr_pkg::*;

    localparam int W = 10;

    typedef struct {
        int       n;
        logic [1:0] tgt;
        bit       multi;
        bit       stuck;
        int       exp_m;
        int       exp_e;
        int       done_cyc;
    } row_t;

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] m;
        logic [W-1:0] e;
    } inj_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] base;
    logic         stuck;
    logic [15:0]  lfsr_m;
    inj_t         exp_q[$];
    row_t         rows[7];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    atmr_fault_injector_if #(.WIDTH(W), .CNT_W(16)) bus ();

    atmr_fault_injector #(
        .WIDTH(W), .SETTLE_CYC(2), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rep_ori = base ^ bus.inj_ori;
    assign bus.rep_mai = base ^ bus.inj_mai;
    assign bus.rep_men = base ^ bus.inj_men;
    assign bus.voted   = stuck ? bus.rep_ori :
                         W'(maj3(32'(bus.rep_ori), 32'(bus.rep_mai),
                                 32'(bus.rep_men)));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic run(input row_t c);
        inj_t         e;
        logic [W-1:0] m, last;
        int           idx, who, cyc;
        bit           seen;
        base  = W'($urandom);
        stuck = c.stuck;
        last  = '0;
        exp_q.delete();
        for (int i = 0; i < c.n; i++) begin
            idx = int'(lfsr_m[3:0]) % W;
            m = W'(1) << idx;
            if (c.multi) m = m | (W'(1) << ((idx + 1) % W));
            who = (c.tgt == 2'd3) ? (i % 3) : int'(c.tgt);
            e.o = (who == 0) ? m : '0;
            e.m = (who == 1) ? m : '0;
            e.e = (who == 2) ? m : '0;
            exp_q.push_back(e);
            last = m;
            lfsr_m = step(lfsr_m);
        end
        @(negedge clk);
        bus.start     = 1'b1;
        bus.n_inject  = 16'(c.n);
        bus.target    = c.tgt;
        bus.multi_bit = c.multi;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        chk("busy_arm", 32'(bus.busy), 1);
        while (!seen && cyc < c.done_cyc + 8) begin
            if (cyc >= 3 && (cyc - 3) % 4 == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inj_ori", 32'(bus.inj_ori), 32'(e.o));
                chk("inj_mai", 32'(bus.inj_mai), 32'(e.m));
                chk("inj_men", 32'(bus.inj_men), 32'(e.e));
            end
            if (cyc >= 6 && (cyc - 6) % 4 == 0 && cyc <= c.done_cyc)
                chk("disagree_nz", 32'(bus.disagree != '0), 1);
            if (cyc == 2)
                chk("busy_c2", 32'(bus.busy), 32'(c.n != 0));
            if (bus.done) begin
                seen = 1'b1;
                chk("done_cyc", 32'(cyc), 32'(c.done_cyc));
                chk("masked", 32'(bus.masked_cnt), 32'(c.exp_m));
                chk("escaped", 32'(bus.escaped_cnt), 32'(c.exp_e));
                chk("disagree", 32'(bus.disagree), 32'(last));
                chk("masks_off", 32'(bus.inj_ori | bus.inj_mai | bus.inj_men), 0);
                chk("busy_done", 32'(bus.busy), 0);
            end else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        chk("done_seen", 32'(seen), 1);
        chk("sb_left", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("cnt_hold", 32'(bus.masked_cnt), 32'(c.exp_m));
    endtask

    initial begin
        logic [15:0] l;
        int          k;
        row_t        r;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.n_inject  = '0;
        bus.target    = 2'd0;
        bus.multi_bit = 1'b0;
        base          = '0;
        stuck         = 1'b0;
        lfsr_m        = 16'hACE1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_inj", 32'(bus.inj_ori | bus.inj_mai | bus.inj_men), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_masked", 32'(bus.masked_cnt), 0);
        chk("rst_escaped", 32'(bus.escaped_cnt), 0);
        chk("rst_disagree", 32'(bus.disagree), 0);
        @(negedge clk) rst_n = 1'b1;

        rows[0] = '{4, 2'd0, 1'b0, 1'b0, 4, 0, 18};
        rows[1] = '{3, 2'd3, 1'b0, 1'b0, 3, 0, 14};
        rows[2] = '{5, 2'd0, 1'b0, 1'b1, 0, 5, 22};
        rows[3] = '{0, 2'd0, 1'b0, 1'b0, 0, 0, 2};
        rows[4] = '{3, 2'd3, 1'b1, 1'b1, 2, 1, 14};
        rows[5] = '{2, 2'd2, 1'b1, 1'b0, 2, 0, 10};
        rows[6] = '{2, 2'd1, 1'b0, 1'b1, 2, 0, 10};
        for (int i = 0; i < 7; i++) run(rows[i]);

        // walk the reference LFSR to the next index-9 draw
        l = lfsr_m;
        k = -1;
        for (int j = 0; j < 64 && k < 0; j++) begin
            if (l[3:0] == 4'd9) k = j;
            l = step(l);
        end
        if (k < 0) begin
            total++;
            bad++;
            $display("FAIL mb_search: got none want idx 9 within 64 draws");
        end else begin
            r = '{k + 1, 2'd0, 1'b1, 1'b0, k + 1, 0, 2 + 4 * (k + 1)};
            run(r);
            chk("mb_idx9", 32'(bus.disagree), 32'h201);
        end

        base  = W'($urandom);
        stuck = 1'b0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.n_inject  = 16'd4;
        bus.target    = 2'd0;
        bus.multi_bit = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_mask", 32'(bus.inj_ori != '0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_inj", 32'(bus.inj_ori | bus.inj_mai | bus.inj_men), 0);
        chk("rst_async_busy", 32'(bus.busy), 0);
        chk("rst_async_done", 32'(bus.done), 0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("rst_no_done", 32'(bus.done), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        lfsr_m = 16'hACE1;
        run(rows[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
